simt_icache_responder: RTL and testbench

- Responder end of the fetch-stage instruction memory interface (imem_req/imem_addr/imem_rdata/imem_valid).
- Direct-mapped, read-only instruction cache. Serves single-word fetches from on-chip lines and refills misses from a backing memory over a request/ready plus beat-valid port.
- Sits between the SIMT fetch stage and the L2/global memory arbiter.

---
 rtl/simt_icache_responder.sv | 184 ++++++++++++++++++
 tb/tb_simt_icache_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simt_icache_responder.sv
// Direct-mapped read-only instruction cache answering single-word fetches,
// refilling whole lines from backing memory on a miss.
module simt_icache_responder #(
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int LINE_WORDS  = 4,
   parameter int NUM_LINES   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   imem_req,
   input  logic [ADDR_WIDTH-1:0]  imem_addr,
   output logic [INSTR_WIDTH-1:0] imem_rdata,
   output logic                   imem_valid,
   input  logic                   invalidate_all,
   output logic                   mem_req,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   input  logic                   mem_ready,
   input  logic                   mem_rvalid,
   input  logic [INSTR_WIDTH-1:0] mem_rdata,
   output logic [31:0]            hit_count,
   output logic [31:0]            miss_count
);

   // state       | meaning
   // S_IDLE      | waiting for a fetch request
   // S_LOOKUP    | tag compare on the latched address
   // S_REFILL_REQ| holding mem_req until backing memory accepts
   // S_REFILL_DATA| collecting line beats in ascending order
   // S_RESPOND   | one-cycle response strobe (suppressed if a newer request is pending)

   localparam int OFF_W   = $clog2(LINE_WORDS);
   localparam int IDX_W   = $clog2(NUM_LINES);
   localparam int TAG_LSB = 2 + OFF_W + IDX_W;
   localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);
   localparam logic [OFF_W-1:0]      LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_REFILL_REQ, S_REFILL_DATA, S_RESPOND
   } state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
   logic                    pend_q, pend_d;
   logic                    inv_q, inv_d;
   logic [OFF_W-1:0]        beat_q, beat_d;
   logic [INSTR_WIDTH-1:0]  word_q, word_d;
   logic [INSTR_WIDTH-1:0]  rdata_q, rdata_d;
   logic [31:0]             hit_q, hit_d;
   logic [31:0]             miss_q, miss_d;
   logic [NUM_LINES-1:0]    valid_q, valid_d;

   logic [TAG_W-1:0]        tag_mem_q  [NUM_LINES];
   logic [INSTR_WIDTH-1:0]  data_mem_q [NUM_LINES*LINE_WORDS];

   logic                    data_we;
   logic                    tag_we;
   logic [OFF_W-1:0]        off;
   logic [IDX_W-1:0]        idx;
   logic [TAG_W-1:0]        tag;
   logic                    hit;

   assign off = addr_q[2 +: OFF_W];
   assign idx = addr_q[2+OFF_W +: IDX_W];
   assign tag = addr_q[TAG_LSB +: TAG_W];
   assign hit = valid_q[idx] && (tag_mem_q[idx] == tag);

   // A request arriving in the RESPOND cycle supersedes that response.
   assign imem_valid = (state_q == S_RESPOND) && !pend_q && !imem_req;
   assign imem_rdata = imem_valid ? word_q : rdata_q;
   assign mem_req    = (state_q == S_REFILL_REQ);
   assign mem_addr   = addr_q & ~LINE_MASK;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      pend_addr_d = pend_addr_q;
      pend_d      = pend_q;
      inv_d       = inv_q;
      beat_d      = beat_q;
      word_d      = word_q;
      rdata_d     = imem_valid ? word_q : rdata_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      valid_d     = valid_q;
      data_we     = 1'b0;
      tag_we      = 1'b0;

      if (imem_req && (state_q != S_IDLE)) begin
         pend_d      = 1'b1;
         pend_addr_d = imem_addr;
      end
      if (invalidate_all) begin
         valid_d = '0;
         if ((state_q == S_REFILL_REQ) || (state_q == S_REFILL_DATA)) inv_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (imem_req) begin
               addr_d  = imem_addr;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               word_d  = data_mem_q[{idx, off}];
               hit_d   = hit_q + 32'd1;
               state_d = S_RESPOND;
            end else begin
               miss_d  = miss_q + 32'd1;
               inv_d   = 1'b0;
               beat_d  = '0;
               state_d = S_REFILL_REQ;
            end
         end
         S_REFILL_REQ: begin
            if (mem_ready) state_d = S_REFILL_DATA;
         end
         S_REFILL_DATA: begin
            if (mem_rvalid) begin
               data_we = 1'b1;
               beat_d  = beat_q + 1'b1;
               if (beat_q == off) word_d = mem_rdata;
               if (beat_q == LAST_BEAT) begin
                  tag_we = 1'b1;
                  // An invalidate seen during the refill keeps the line unusable.
                  if (!inv_q && !invalidate_all) valid_d[idx] = 1'b1;
                  state_d = S_RESPOND;
               end
            end
         end
         S_RESPOND: begin
            if (pend_q || imem_req) begin
               addr_d  = imem_req ? imem_addr : pend_addr_q;
               pend_d  = 1'b0;
               state_d = S_LOOKUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         pend_addr_q <= '0;
         pend_q      <= 1'b0;
         inv_q       <= 1'b0;
         beat_q      <= '0;
         word_q      <= '0;
         rdata_q     <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         pend_addr_q <= pend_addr_d;
         pend_q      <= pend_d;
         inv_q       <= inv_d;
         beat_q      <= beat_d;
         word_q      <= word_d;
         rdata_q     <= rdata_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         valid_q     <= valid_d;
      end
   end

   // Line storage needs no reset: valid bits gate every read.
   always_ff @(posedge clk) begin
      if (data_we) data_mem_q[{idx, beat_q}] <= mem_rdata;
      if (tag_we)  tag_mem_q[idx] <= tag;
   end

endmodule

// File: tb/tb_simt_icache_responder.sv
// Directed bench for simt_icache_responder: cold miss, hit latency, eviction,
// re-issued fetches, invalidation during refill and reset mid-refill.
module tb_simt_icache_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        invalidate_all;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          vcnt = 0;
   int          vcyc = 0;
   logic [31:0] vdata = '0;
   int          acc_cnt = 0;
   logic [31:0] acc_addr = '0;

   simt_icache_responder dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_valid(imem_valid),
      .invalidate_all(invalidate_all),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Mid-cycle observer of response strobes and refill handshakes.
   always @(negedge clk) begin
      if (imem_valid) begin
         vcnt  <= vcnt + 1;
         vdata <= imem_rdata;
         vcyc  <= cyc;
      end
      if (mem_req && mem_ready) begin
         acc_cnt  <= acc_cnt + 1;
         acc_addr <= mem_addr;
      end
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout observed running expected finished");
      $fatal(1, "bench timed out");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input logic [31:0] a);
      imem_req  = 1'b1;
      imem_addr = a;
      tick;
      imem_req  = 1'b0;
   endtask

   task automatic wait_mem_req;
      int n = 0;
      while (!mem_req && n < 40) begin
         tick;
         n++;
      end
      if (!mem_req) chk("mem_req_wait", {31'b0, mem_req}, 32'd1);
   endtask

   task automatic serve(input logic [31:0] d0, input int rdy_dly, input int gap);
      wait_mem_req;
      repeat (rdy_dly) tick;
      mem_ready = 1'b1;
      tick;
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = d0 + i;
         tick;
         mem_rvalid = 1'b0;
         repeat (gap) tick;
      end
   endtask

   task automatic settle;
      repeat (3) tick;
   endtask

   task automatic chk_reset_outputs(input string pfx);
      chk({pfx, "_imem_valid"}, {31'b0, imem_valid}, 32'd0);
      chk({pfx, "_imem_rdata"}, imem_rdata, 32'd0);
      chk({pfx, "_mem_req"},    {31'b0, mem_req}, 32'd0);
      chk({pfx, "_mem_addr"},   mem_addr, 32'd0);
      chk({pfx, "_hit_count"},  hit_count, 32'd0);
      chk({pfx, "_miss_count"}, miss_count, 32'd0);
   endtask

   initial begin
      int base;
      int base_acc;
      int req_cyc;

      rst = 1'b1; imem_req = 1'b0; imem_addr = '0; invalidate_all = 1'b0;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      repeat (2) tick;
      chk_reset_outputs("reset");
      rst = 1'b0;
      tick;

      // Cold miss on 0x100, ready three cycles after mem_req rises.
      fetch(32'h100);
      serve(32'hA0, 3, 0);
      settle;
      chk("cold_valid_count", vcnt, 1);
      chk("cold_rdata", vdata, 32'hA0);
      chk("cold_mem_addr", acc_addr, 32'h100);
      chk("cold_miss_count", miss_count, 32'd1);

      // Hit on word 3 of the same line.
      base = vcnt; base_acc = acc_cnt; req_cyc = cyc;
      fetch(32'h10C);
      settle;
      chk("hit_valid_count", vcnt, base + 1);
      chk("hit_latency", vcyc - req_cyc, 32'd2);
      chk("hit_rdata", vdata, 32'hA3);
      chk("hit_count", hit_count, 32'd1);
      chk("hit_no_refill", acc_cnt, base_acc);
      repeat (5) tick;
      chk("hit_rdata_hold", imem_rdata, 32'hA3);

      // 0x100, 0x200 share index 0: each evicts the other.
      fetch(32'h200);
      serve(32'hB0, 1, 1);
      settle;
      chk("conflict_rdata_200", vdata, 32'hB0);
      fetch(32'h100);
      serve(32'hC0, 0, 0);
      settle;
      chk("conflict_miss_count", miss_count, 32'd3);
      chk("conflict_rdata_100", vdata, 32'hC0);
      chk("conflict_mem_addr", acc_addr, 32'h100);

      // Re-issue 0x104 while 0x300 refills. Both index 0, so the installed
      // 0x300 line is evicted by the 0x100 refill and 0x300 misses again.
      base = vcnt;
      fetch(32'h300);
      wait_mem_req;
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'hD0; tick;
      mem_rdata = 32'hD1; imem_req = 1'b1; imem_addr = 32'h104; tick;
      imem_req = 1'b0;
      mem_rdata = 32'hD2; tick;
      mem_rdata = 32'hD3; tick;
      mem_rvalid = 1'b0;
      serve(32'hE0, 0, 0);
      settle;
      chk("reissue_single_valid", vcnt, base + 1);
      chk("reissue_rdata", vdata, 32'hE1);
      chk("reissue_miss_count", miss_count, 32'd5);
      fetch(32'h300);
      serve(32'hF0, 0, 0);
      settle;
      chk("reissue_300_miss", miss_count, 32'd6);

      // Re-issue to a different index: the superseded 0x600 line is still installed.
      base = vcnt;
      fetch(32'h600);
      tick;
      imem_req = 1'b1; imem_addr = 32'h114; tick;
      imem_req = 1'b0;
      serve(32'h60, 1, 0);
      serve(32'h50, 0, 0);
      settle;
      chk("reissue2_single_valid", vcnt, base + 1);
      chk("reissue2_rdata", vdata, 32'h51);
      chk("reissue2_mem_addr", acc_addr, 32'h110);
      fetch(32'h600);
      settle;
      chk("installed_600_hit", hit_count, 32'd2);
      chk("installed_600_rdata", vdata, 32'h60);

      // Invalidate during refill of 0x400: data returned, nothing stays valid.
      fetch(32'h400);
      wait_mem_req;
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h40; tick;
      mem_rdata = 32'h41; invalidate_all = 1'b1; tick;
      invalidate_all = 1'b0;
      mem_rdata = 32'h42; tick;
      mem_rdata = 32'h43; tick;
      mem_rvalid = 1'b0;
      settle;
      chk("inval_rdata", vdata, 32'h40);
      chk("inval_miss_count", miss_count, 32'd9);
      fetch(32'h400);
      serve(32'h40, 0, 0);
      settle;
      chk("inval_400_remiss", miss_count, 32'd10);
      fetch(32'h110);
      serve(32'h50, 0, 0);
      settle;
      chk("inval_110_remiss", miss_count, 32'd11);

      // Reset after two beats of a refill; trailing beats must be ignored.
      fetch(32'h500);
      wait_mem_req;
      mem_ready = 1'b1; tick; mem_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h90; tick;
      mem_rdata = 32'h91; tick;
      mem_rvalid = 1'b0;
      rst = 1'b1; tick; rst = 1'b0;
      chk_reset_outputs("midrst");
      base = vcnt;
      mem_rvalid = 1'b1; mem_rdata = 32'h92; tick;
      mem_rdata = 32'h93; tick;
      mem_rvalid = 1'b0;
      tick;
      chk("midrst_no_valid", vcnt, base);
      chk("midrst_no_mem_req", {31'b0, mem_req}, 32'd0);
      fetch(32'h500);
      tick;
      chk("midrst_new_mem_req", {31'b0, mem_req}, 32'd1);
      chk("midrst_new_mem_addr", mem_addr, 32'h500);
      serve(32'h70, 0, 0);
      settle;
      chk("midrst_rdata", vdata, 32'h70);
      chk("midrst_miss_count", miss_count, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
